ita_hwpe_job_scheduler: RTL and testbench

ITA_HWPE_JOB_SCHEDULER -- requirements
Module: ita_hwpe_job_scheduler

---
 rtl/ita_hwpe_job_scheduler.sv | 146 ++++++++++++++
 tb/tb_ita_hwpe_job_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_hwpe_job_scheduler.sv
// ita_hwpe_job_scheduler
// Queues engine job descriptors in a small FIFO and sequences them one at a
// time: start pulse, wait for the engine to go busy (bounded), wait for it to
// go idle again (unbounded), then a done pulse with an optional timeout error.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no job in flight; pops the FIFO head into ctrl_o if present
// START     | start_o pulse to the engine, timeout timer loaded
// WAIT_BUSY | waiting for eng_busy_i; timer expiry ends the job with error
// RUN       | engine busy; waits for eng_busy_i to drop
// DONE      | done_o pulse (err_o too on timeout); always returns to IDLE
module ita_hwpe_job_scheduler #(
    parameter int unsigned CTRL_W   = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned START_TO = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       desc_valid_i,
    output logic                       desc_ready_o,
    input  logic [CTRL_W-1:0]          desc_i,
    input  logic                       clear_i,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic                       start_o,
    input  logic                       eng_busy_i,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     pending_o,
    output logic [15:0]                jobs_done_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(START_TO - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         count_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [TW-1:0]       tmr_q;
    logic                err_q;
    logic [15:0]         jobs_done_q;
    logic                push, pop, timeout;

    assign desc_ready_o = (count_q != FULL_CNT);
    assign push         = desc_valid_i && desc_ready_o;
    assign pop          = (state_q == IDLE) && (count_q != '0);
    // Timer counts down from START_TO-1; reaching zero while still waiting
    // means START_TO idle cycles have elapsed in WAIT_BUSY.
    assign timeout      = (state_q == WAIT_BUSY) && !eng_busy_i && (tmr_q == '0);

    assign ctrl_o      = ctrl_q;
    assign pending_o   = count_q;
    assign jobs_done_o = jobs_done_q;

    // Descriptor storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem[wptr_q] <= desc_i;
        end
    end

    // FIFO pointers and occupancy; clear wins over a same-cycle push.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
            else if (!push && pop) count_q <= count_q - (AW + 1)'(1);
        end
    end

    // Engine control word captured only when a descriptor is popped.
    always_ff @(posedge clk_i) begin
        if (rst_i)    ctrl_q <= '0;
        else if (pop) ctrl_q <= mem[rptr_q];
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (count_q != '0) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (eng_busy_i)           state_d = RUN;
                else if (tmr_q == '0)     state_d = DONE;
            end
            RUN:       if (!eng_busy_i)   state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        start_o = (state_q == START);
        done_o  = (state_q == DONE);
        err_o   = (state_q == DONE) && err_q;
        busy_o  = (state_q != IDLE) || (count_q != '0);
    end

    // Start-acknowledge timeout down-counter.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                           tmr_q <= '0;
        else if (state_q == START)                           tmr_q <= TMR_LOAD;
        else if (state_q == WAIT_BUSY && !eng_busy_i && tmr_q != '0)
                                                             tmr_q <= tmr_q - TW'(1);
    end

    // Error flag is only consumed in DONE, which is always entered straight
    // from the timeout cycle or from RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= timeout;
    end

    // Completed-job counter; timed-out jobs are not counted.
    always_ff @(posedge clk_i) begin
        if (rst_i)                            jobs_done_q <= '0;
        else if (state_q == DONE && !err_q)   jobs_done_q <= jobs_done_q + 16'd1;
    end

endmodule

// File: tb/tb_ita_hwpe_job_scheduler.sv
// Self-checking bench for ita_hwpe_job_scheduler: a behavioural engine model
// answers start pulses, and a scoreboard checks descriptors start in push order.
module tb_ita_hwpe_job_scheduler;

    localparam int START_TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        desc_valid_i = 1'b0;
    logic        desc_ready_o;
    logic [63:0] desc_i = '0;
    logic        clear_i = 1'b0;
    logic [63:0] ctrl_o;
    logic        start_o;
    logic        eng_busy_i = 1'b0;
    logic        done_o;
    logic        err_o;
    logic        busy_o;
    logic [2:0]  pending_o;
    logic [15:0] jobs_done_o;

    int tests = 0;
    int fails = 0;

    ita_hwpe_job_scheduler #(.CTRL_W(64), .DEPTH(4), .START_TO(START_TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .desc_i       (desc_i),
        .clear_i      (clear_i),
        .ctrl_o       (ctrl_o),
        .start_o      (start_o),
        .eng_busy_i   (eng_busy_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .busy_o       (busy_o),
        .pending_o    (pending_o),
        .jobs_done_o  (jobs_done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    logic [63:0] exp_q[$];

    // engine model controls (set by tasks) and values latched at each start
    bit eng_en = 1'b1;
    int eng_delay = 2;
    int eng_len = 10;
    bit lat_en = 1'b0;
    int lat_delay = 0;
    int lat_len = 0;
    int eng_cnt = 1000;

    int n_start = 0, n_done = 0, n_err = 0;
    int last_start_cyc = 0, last_done_cyc = -10, hs_cyc = 0;
    bit inflight = 1'b0;
    logic [63:0] started_ctrl = '0;
    int lat_exp = 0;
    bit err_exp = 1'b0;

    // Engine model plus scoreboard/monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        logic [63:0] e;
        if (start_o && !rst_i) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_start: ctrl_o=%0h with no queued descriptor", ctrl_o);
            end else begin
                e = exp_q.pop_front();
                if (ctrl_o !== e) begin
                    fails++;
                    $display("FAIL sb_order: ctrl_o=%0h want %0h", ctrl_o, e);
                end
            end
            tests++;
            if (cyc - last_done_cyc < 2) begin
                fails++;
                $display("FAIL idle_gap: start %0d cycles after done, want >= 2", cyc - last_done_cyc);
            end
            eng_cnt = 0;
            lat_en = eng_en;
            lat_delay = eng_delay;
            lat_len = eng_len;
            lat_exp = eng_en ? (eng_delay + eng_len + 1) : (START_TO + 1);
            err_exp = !eng_en;
            started_ctrl = ctrl_o;
            inflight = 1'b1;
            last_start_cyc = cyc;
            n_start++;
        end else begin
            eng_cnt++;
        end
        eng_busy_i = lat_en && (eng_cnt >= lat_delay) && (eng_cnt < lat_delay + lat_len);

        if (rst_i) begin
            inflight = 1'b0;
        end else if (done_o) begin
            tests++;
            if (!inflight) begin
                fails++;
                $display("FAIL done_unexpected: done_o=1 with no job in flight");
            end
            tests++;
            if (cyc - last_start_cyc != lat_exp) begin
                fails++;
                $display("FAIL done_latency: got %0d cycles want %0d", cyc - last_start_cyc, lat_exp);
            end
            tests++;
            if (err_o !== err_exp) begin
                fails++;
                $display("FAIL done_err: err_o=%0b want %0b", err_o, err_exp);
            end
            tests++;
            if (ctrl_o !== started_ctrl) begin
                fails++;
                $display("FAIL ctrl_stable: ctrl_o=%0h want %0h", ctrl_o, started_ctrl);
            end
            if (err_o) n_err++;
            n_done++;
            inflight = 1'b0;
            last_done_cyc = cyc;
        end else if (err_o) begin
            tests++;
            fails++;
            $display("FAIL err_without_done: err_o=1 done_o=0");
        end
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic push(input logic [63:0] d);
        desc_valid_i = 1'b1;
        desc_i = d;
        if (desc_ready_o && !clear_i) begin
            exp_q.push_back(d);
            hs_cyc = cyc;
        end
        step();
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_start(input int n0, input int budget, input string tag);
        int k = 0;
        while (n_start == n0 && k < budget) begin
            step();
            k++;
        end
        tests++;
        if (n_start == n0) begin
            fails++;
            $display("FAIL %s_start_wait: starts=%0d want >%0d within %0d cycles", tag, n_start, n0, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((busy_o !== 1'b0 || inflight) && k < budget) begin
            step();
            k++;
        end
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_wait: busy_o=%0b want 0 within %0d cycles", tag, busy_o, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (ctrl_o !== 64'h0 || start_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
            busy_o !== 1'b0 || pending_o !== 3'd0 || jobs_done_o !== 16'h0 || desc_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL %s: ctrl=%0h start=%0b done=%0b err=%0b busy=%0b pend=%0d jobs=%0h rdy=%0b want 0/0/0/0/0/0/0/1",
                     tag, ctrl_o, start_o, done_o, err_o, busy_o, pending_o, jobs_done_o, desc_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        check_reset_outputs("reset_values");
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_single();
        int n0 = n_start;
        int hs;
        eng_en = 1'b1; eng_delay = 2; eng_len = 10;
        push(64'h1234);
        hs = hs_cyc;
        wait_start(n0, 10, "single");
        tests++;
        if (last_start_cyc - hs != 2) begin
            fails++;
            $display("FAIL single_latency: start %0d cycles after handshake want 2", last_start_cyc - hs);
        end
        wait_idle(40, "single");
        tests++;
        if (jobs_done_o !== 16'd1) begin
            fails++;
            $display("FAIL single_jobs: jobs_done_o=%0d want 1", jobs_done_o);
        end
    endtask

    task automatic test_back_to_back();
        int n0 = n_start;
        int d0 = n_done;
        eng_en = 1'b1; eng_delay = 2; eng_len = 30;
        push(64'hB0);
        wait_start(n0, 10, "b2b_blocker");
        eng_len = 3;
        for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
        tests++;
        if (desc_ready_o !== 1'b0 || pending_o !== 3'd4) begin
            fails++;
            $display("FAIL b2b_full: ready=%0b pending=%0d want 0/4", desc_ready_o, pending_o);
        end
        push(64'hEE);
        wait_idle(200, "b2b");
        tests++;
        if (n_start - n0 != 5 || n_done - d0 != 5 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_counts: starts=%0d dones=%0d left=%0d want 5/5/0", n_start - n0, n_done - d0, exp_q.size());
        end
        tests++;
        if (jobs_done_o !== 16'd6) begin
            fails++;
            $display("FAIL b2b_jobs: jobs_done_o=%0d want 6", jobs_done_o);
        end
    endtask

    task automatic test_timeout();
        int e0 = n_err;
        eng_en = 1'b0;
        push(64'h7070);
        wait_idle(60, "timeout");
        tests++;
        if (n_err - e0 != 1) begin
            fails++;
            $display("FAIL timeout_err: err pulses=%0d want 1", n_err - e0);
        end
        tests++;
        if (jobs_done_o !== 16'd6) begin
            fails++;
            $display("FAIL timeout_jobs: jobs_done_o=%0d want 6", jobs_done_o);
        end
        eng_en = 1'b1;
    endtask

    task automatic test_immediate_wrap();
        int e0 = n_err;
        dut.jobs_done_q = 16'hFFFF;
        step();
        tests++;
        if (jobs_done_o !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload: jobs_done_o=%0h want ffff", jobs_done_o);
        end
        eng_delay = 1; eng_len = 4;
        push(64'h5A5A);
        wait_idle(40, "wrap");
        tests++;
        if (jobs_done_o !== 16'h0000 || n_err != e0) begin
            fails++;
            $display("FAIL wrap_jobs: jobs_done_o=%0h errs=%0d want 0000/0", jobs_done_o, n_err - e0);
        end
    endtask

    task automatic test_clear();
        int n0 = n_start;
        int n1;
        eng_delay = 2; eng_len = 40;
        push(64'hC0);
        wait_start(n0, 10, "clear_blocker");
        eng_len = 3;
        for (int i = 0; i < 3; i++) push(64'hC1 + 64'(i));
        tests++;
        if (pending_o !== 3'd3) begin
            fails++;
            $display("FAIL clear_prefill: pending_o=%0d want 3", pending_o);
        end
        clear_i = 1'b1;
        desc_valid_i = 1'b1;
        desc_i = 64'hDEAD;
        step();
        clear_i = 1'b0;
        desc_valid_i = 1'b0;
        exp_q.delete();
        tests++;
        if (pending_o !== 3'd0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL clear_flush: pending=%0d busy=%0b want 0/1", pending_o, busy_o);
        end
        n1 = n_start;
        wait_idle(80, "clear");
        for (int i = 0; i < 10; i++) step();
        tests++;
        if (n_start != n1 || jobs_done_o !== 16'd1) begin
            fails++;
            $display("FAIL clear_after: extra starts=%0d jobs=%0d want 0/1", n_start - n1, jobs_done_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int n0 = n_start;
        int d0;
        int n1;
        int hs;
        eng_delay = 2; eng_len = 40;
        push(64'hD0);
        wait_start(n0, 10, "rst_blocker");
        push(64'hD1);
        push(64'hD2);
        step();
        step();
        rst_i = 1'b1;
        exp_q.delete();
        step();
        check_reset_outputs("rst_mid_values");
        rst_i = 1'b0;
        d0 = n_done;
        n1 = n_start;
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (n_start != n1 || n_done != d0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_quiet: starts=%0d dones=%0d busy=%0b want 0/0/0", n_start - n1, n_done - d0, busy_o);
        end
        eng_len = 3;
        push(64'h99);
        hs = hs_cyc;
        wait_start(n1, 10, "rst_restart");
        tests++;
        if (last_start_cyc - hs != 2) begin
            fails++;
            $display("FAIL rst_restart_latency: %0d cycles want 2", last_start_cyc - hs);
        end
        wait_idle(40, "rst_restart");
        tests++;
        if (jobs_done_o !== 16'd1) begin
            fails++;
            $display("FAIL rst_restart_jobs: jobs_done_o=%0d want 1", jobs_done_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_immediate_wrap();
        test_clear();
        test_reset_mid_run();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
